add16: RTL and testbench

- 16-bit two's-complement/unsigned adder for the Hack datapath. The ALU uses it for the x+y function, and the PC/incrementer path uses it with b = 1.
- Primary result is purely combinational: sum = a + b mod 2^16, with no clock involvement.
- A registered copy of the result and carry is also provided for pipelined consumers. This registered path uses the block's single clock and asynchronous active-low reset.

---
 rtl/add16.sv | 52 +++++
 tb/tb_add16.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/add16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | add16 : 16-bit gate-level ripple adder with registered sum/carry copy |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module add16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry,
    output logic [15:0] sum_q,
    output logic        carry_q
);

    // w_c[i] is the carry into bit i; w_c[16] is the carry-out of the chain.
    logic [16:1] w_c;
    logic [15:0] r_sum_q;
    logic        r_carry_q;

    generate
        for (genvar i = 0; i < 16; i++) begin : g_bit
            if (i == 0) begin : g_ha
                assign sum[i]   = a[i] ^ b[i];
                assign w_c[i+1] = a[i] & b[i];
            end else begin : g_fa
                logic w_p;
                assign w_p      = a[i] ^ b[i];
                assign sum[i]   = w_p ^ w_c[i];
                assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & w_p);
            end
        end
    endgenerate

    assign carry = w_c[16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_q   <= 16'h0000;
            r_carry_q <= 1'b0;
        end else begin
            r_sum_q   <= sum;
            r_carry_q <= carry;
        end
    end

    assign sum_q   = r_sum_q;
    assign carry_q = r_carry_q;

endmodule
`default_nettype wire

// File: tb/tb_add16.sv
`default_nettype none
// Testbench for add16: scoreboard queues for the combinational and registered
// paths, directed boundary vectors, a reset sequence and a random sweep.
module tb_add16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        carry;
    logic [15:0] sum_q;
    logic        carry_q;

    int tests;
    int fails;

    logic [16:0] comb_q[$];
    logic [16:0] reg_q[$];

    add16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .sum     (sum),
        .carry   (carry),
        .sum_q   (sum_q),
        .carry_q (carry_q)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (a=%h b=%h)", name, act, exp, a, b);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        int unsigned s;
        s = int'(x) + int'(y);
        return s[16:0];
    endfunction

    // Drive one vector at the falling edge and record what both paths must show.
    task automatic apply(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a = x;
        b = y;
        comb_q.push_back(ref_add(x, y));
        reg_q.push_back(ref_add(x, y));
    endtask

    // Combinational monitor: checks 9 ns after the inputs change.
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            #9;
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                check("comb", {carry, sum}, e);
            end
        end
    end

    // Registered monitor: checks just after the capturing rising edge.
    initial begin
        logic [16:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check("reg", {carry_q, sum_q}, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;

        #5;
        check("reset_reg", {carry_q, sum_q}, 17'h00000);
        check("reset_comb", {carry, sum}, 17'h00000);

        @(negedge clk);
        rst_n = 1'b1;

        apply(16'h0000, 16'h0000);
        apply(16'hFFFF, 16'h0001);
        apply(16'hAAAA, 16'h5555);
        apply(16'h1234, 16'h4321);
        apply(16'hFFFF, 16'hFFFF);
        apply(16'h8000, 16'h8000);

        // Reset sequence: capture FFFF+0001, then assert reset between edges.
        apply(16'hFFFF, 16'h0001);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_reg", {carry_q, sum_q}, 17'h00000);
        check("rst_live_comb", {carry, sum}, 17'h10000);
        @(negedge clk);
        a = 16'h1234;
        b = 16'h4321;
        @(posedge clk);
        #1;
        check("rst_hold_reg", {carry_q, sum_q}, 17'h00000);
        check("rst_live_comb2", {carry, sum}, 17'h05555);
        #2;
        rst_n = 1'b1;
        apply(16'h1234, 16'h4321);

        for (int i = 0; i < 1000; i++) begin
            apply(16'($urandom), 16'($urandom));
        end

        repeat (4) @(posedge clk);
        #2;
        tests++;
        if (comb_q.size() != 0 || reg_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", comb_q.size(), reg_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
